// File: rtl/bfm_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bfm_apb_pkg
// Purpose  : Shared definitions for the APB3 completer memory BFM:
//            FSM state encoding, LFSR tap constant, default seed and the
//            LFSR step function.
// Revision : 1.0  initial release
// ============================================================================
package bfm_apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial:
    // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
    localparam logic [15:0] c_lfsr_taps         = 16'h002D;
    localparam logic [15:0] c_lfsr_seed_default = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
        return {^(i_state & c_lfsr_taps), i_state[15:1]};
    endfunction

endpackage : bfm_apb_pkg
`default_nettype wire

// File: rtl/bfm_apb_wait_gen.sv
`default_nettype none
// ============================================================================
// Module   : bfm_apb_wait_gen
// Purpose  : Wait-state generator: a 16-bit LFSR plus a down-counter.
//            On i_load the counter takes either the fixed count or the
//            masked LFSR nibble, and the LFSR advances one step.
//            On i_step the counter decrements until it reaches zero.
// Ports    : clk      in  clock
//            rst_n    in  synchronous active-low reset
//            i_load   in  load counter / advance LFSR
//            i_step   in  decrement request
//            i_mode   in  1 = random (LFSR) count, 0 = fixed count
//            i_fixed  in  fixed wait count
//            i_mask   in  mask applied to the LFSR nibble
//            o_ready  out counter is zero
// Revision : 1.0  initial release
// ============================================================================
module bfm_apb_wait_gen
    import bfm_apb_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = c_lfsr_seed_default
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic       i_mode,
    input  logic [3:0] i_fixed,
    input  logic [3:0] i_mask,
    output logic       o_ready
);

    logic [15:0] r_lfsr;
    logic [3:0]  r_wcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_wcnt <= 4'd0;
        end else if (i_load) begin
            r_wcnt <= i_mode ? (r_lfsr[3:0] & i_mask) : i_fixed;
            r_lfsr <= lfsr_next(r_lfsr);
        end else if (i_step && (r_wcnt != 4'd0)) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end

    assign o_ready = (r_wcnt == 4'd0);

endmodule : bfm_apb_wait_gen
`default_nettype wire

// File: rtl/bfm_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : bfm_apb_slave_mem
// Purpose  : APB3 completer BFM backed by a word-addressed memory.
//            Fixed or pseudo-random wait states, PSLVERR for an address
//            window / misaligned / out-of-range accesses, sticky protocol
//            violation flag and a completed-transfer counter.
// Ports    : PCLK, PRESETN (sync active-low), PSEL, PENABLE, PWRITE,
//            PADDR[31:0], PWDATA[31:0] in;
//            PRDATA[31:0], PREADY, PSLVERR, PROT_ERR, XFER_COUNT[15:0] out.
// Revision : 1.0  initial release
// ============================================================================
module bfm_apb_slave_mem
    import bfm_apb_pkg::*;
#(
    parameter int          AWIDTH      = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter bit          RAND_WAIT   = 1'b0,
    parameter logic [3:0]  WAIT_MASK   = 4'hF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_FFFF,
    parameter logic [31:0] ERR_MASK    = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PROT_ERR,
    output logic [15:0] XFER_COUNT
);

    apb_state_t  r_state;
    apb_state_t  w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_prot_err;
    logic [15:0] r_xfer_count;
    logic [31:0] r_mem [0:(2**AWIDTH)-1];

    logic              w_setup;
    logic              w_no_setup;
    logic              w_access_ok;
    logic              w_abort;
    logic              w_complete;
    logic              w_commit;
    logic              w_ready;
    logic              w_addr_err;
    logic [AWIDTH-1:0] w_idx;
    logic [AWIDTH-1:0] r_idx;

    assign w_idx      = PADDR[AWIDTH+1:2];
    assign w_addr_err = ((PADDR & ERR_MASK) == ERR_BASE)
                      | (PADDR[1:0] != 2'b00)
                      | (PADDR[31:AWIDTH+2] != '0);

    assign w_setup    = (r_state == ST_IDLE) && PSEL && !PENABLE;
    assign w_no_setup = (r_state == ST_IDLE) && PSEL && PENABLE;

    // The access phase is legal only while the master holds the bus
    // exactly as it was presented in the setup phase.
    assign w_access_ok = (r_state == ST_ACCESS) && PSEL && PENABLE
                      && (PADDR == r_addr) && (PWRITE == r_write)
                      && (PWDATA == r_wdata);
    assign w_abort     = (r_state == ST_ACCESS) && !w_access_ok;
    assign w_complete  = w_access_ok && w_ready;
    assign w_commit    = PRESETN && w_complete && r_write && !r_err;

    bfm_apb_wait_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_wait_gen (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .i_load  (w_setup),
        .i_step  (w_access_ok),
        .i_mode  (RAND_WAIT),
        .i_fixed (4'(WAIT_CYCLES)),
        .i_mask  (WAIT_MASK),
        .o_ready (w_ready)
    );

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_complete || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Setup latch, read data, flags and counter
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_rdata      <= '0;
            r_prot_err   <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            if (w_setup) begin
                r_addr  <= PADDR;
                r_wdata <= PWDATA;
                r_write <= PWRITE;
                r_err   <= w_addr_err;
                r_idx   <= w_idx;
                r_rdata <= (!PWRITE && !w_addr_err) ? r_mem[w_idx] : '0;
            end
            if (w_no_setup || w_abort) begin
                r_prot_err <= 1'b1;
            end
            if (w_complete) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    // Memory array carries no reset; the commit term already excludes
    // cycles in which reset is asserted.
    always_ff @(posedge PCLK) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign PRDATA     = r_rdata;
    assign PREADY     = (r_state == ST_ACCESS) && w_ready;
    assign PSLVERR    = PREADY && r_err;
    assign PROT_ERR   = r_prot_err;
    assign XFER_COUNT = r_xfer_count;

endmodule : bfm_apb_slave_mem
`default_nettype wire

// File: tb/tb_bfm_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfm_apb_slave_mem
// Purpose  : Self-checking bench for bfm_apb_slave_mem. Three instances:
//            0 = no waits with error window 0x1xx, 1 = three fixed waits,
//            2 = random waits from the LFSR.
// Revision : 1.0  initial release
// ============================================================================
module tb_bfm_apb_slave_mem;

    logic             clk = 1'b0;
    logic             prstn = 1'b0;
    logic [2:0]       psel = '0;
    logic             penable = 1'b0;
    logic             pwrite = 1'b0;
    logic [31:0]      paddr = '0;
    logic [31:0]      pwdata = '0;
    logic [2:0][31:0] prdata;
    logic [2:0]       pready;
    logic [2:0]       pslverr;
    logic [2:0]       prot_err;
    logic [2:0][15:0] xcnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt [3] = '{0, 0, 0};
    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    bfm_apb_slave_mem #(.WAIT_CYCLES(0), .ERR_BASE(32'h100), .ERR_MASK(32'hF00)) u_err (
        .PCLK(clk), .PRESETN(prstn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .PROT_ERR(prot_err[0]), .XFER_COUNT(xcnt[0]));

    bfm_apb_slave_mem #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESETN(prstn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .PROT_ERR(prot_err[1]), .XFER_COUNT(xcnt[1]));

    bfm_apb_slave_mem #(.RAND_WAIT(1'b1), .WAIT_MASK(4'hF), .LFSR_SEED(16'hACE1)) u_rnd (
        .PCLK(clk), .PRESETN(prstn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]), .PROT_ERR(prot_err[2]), .XFER_COUNT(xcnt[2]));

    typedef struct {
        int          dut;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_waits;
    } vec_t;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One complete APB transfer; returns data sampled with PREADY and the
    // number of clock edges the transfer took (setup through completion).
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int ncyc);
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        ncyc    = 0;
        @(posedge clk); #1; ncyc++;
        penable = 1'b1;
        while (!pready[d] && ncyc < 40) begin
            @(posedge clk); #1; ncyc++;
        end
        rd = prdata[d];
        er = pslverr[d];
        @(posedge clk); #1; ncyc++;
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic do_chk(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err, input int exp_waits);
        logic [31:0] rd;
        bit          er;
        int          n;
        xfer(d, wr, a, wd, rd, er, n);
        exp_cnt[d]++;
        chk($sformatf("rdata d%0d a%0h", d, a), rd, exp_rd);
        chk($sformatf("slverr d%0d a%0h", d, a), 32'(er), 32'(exp_err));
        chk($sformatf("cycles d%0d a%0h", d, a), 32'(n), 32'(2 + exp_waits));
        chk($sformatf("count d%0d", d), 32'(xcnt[d]), 32'(exp_cnt[d]));
        chk($sformatf("pready_low d%0d", d), 32'(pready[d]), 32'd0);
    endtask

    task automatic rnd_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd);
        int w;
        w      = int'(m_lfsr[3:0]);
        m_lfsr = ref_step(m_lfsr);
        do_chk(2, wr, a, wd, exp_rd, 1'b0, w);
    endtask

    initial begin
        vec_t        vecs [$];
        logic [31:0] addrs [64];
        logic [31:0] mdl [logic [31:0]];
        logic [31:0] a;
        logic [31:0] d;

        vecs.push_back('{0, 1'b1, 32'h10,   32'hCAFEF00D, 32'h0,        1'b0, 0});
        vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        32'hCAFEF00D, 1'b0, 0});
        vecs.push_back('{0, 1'b1, 32'h104,  32'h1234,     32'h0,        1'b1, 0});
        vecs.push_back('{0, 1'b0, 32'h104,  32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{0, 1'b1, 32'h0,    32'h0BADF00D, 32'h0,        1'b0, 0});
        vecs.push_back('{0, 1'b1, 32'h3,    32'h55,       32'h0,        1'b1, 0});
        vecs.push_back('{0, 1'b1, 32'h1000, 32'h77,       32'h0,        1'b1, 0});
        vecs.push_back('{0, 1'b0, 32'h0,    32'h0,        32'h0BADF00D, 1'b0, 0});
        vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{1, 1'b1, 32'h0,    32'h13579BDF, 32'h0,        1'b0, 3});
        vecs.push_back('{1, 1'b0, 32'h0,    32'h0,        32'h13579BDF, 1'b0, 3});

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst prdata",  prdata[0], 32'h0);
        chk("rst pready",  32'(pready), 32'h0);
        chk("rst pslverr", 32'(pslverr), 32'h0);
        chk("rst prot",    32'(prot_err), 32'h0);
        chk("rst count",   32'(xcnt[0]), 32'h0);
        prstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed transfers
        foreach (vecs[i]) begin
            do_chk(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_waits);
        end

        // PSEL dropped during a waited access
        do_chk(1, 1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0, 3);
        psel[1] = 1'b1; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h22222222; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0;
        @(posedge clk); #1;
        penable = 1'b0;
        chk("abort prot",   32'(prot_err[1]), 32'd1);
        chk("abort pready", 32'(pready[1]), 32'd0);
        chk("abort count",  32'(xcnt[1]), 32'(exp_cnt[1]));
        do_chk(1, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 3);

        // Random waits, back-to-back writes then reads
        for (int i = 0; i < 64; i++) begin
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            d = $urandom;
            addrs[i] = a;
            mdl[a]   = d;
            rnd_xfer(1'b1, a, d, 32'h0);
        end
        for (int i = 0; i < 64; i++) begin
            rnd_xfer(1'b0, addrs[i], 32'h0, mdl[addrs[i]]);
        end

        // Access phase without setup
        chk("nosetup pre", 32'(prot_err[0]), 32'd0);
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        @(posedge clk); #1;
        psel[0] = 1'b0; penable = 1'b0;
        chk("nosetup prot",   32'(prot_err[0]), 32'd1);
        chk("nosetup pready", 32'(pready[0]), 32'd0);
        chk("nosetup count",  32'(xcnt[0]), 32'(exp_cnt[0]));

        // Reset at the completing edge of a write
        do_chk(1, 1'b1, 32'h80, 32'hAAAA5555, 32'h0, 1'b0, 3);
        do_chk(0, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        psel[1] = 1'b1; pwrite = 1'b1; paddr = 32'h80; pwdata = 32'hDEADBEEF; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 20 && !pready[1]; k++) begin
            @(posedge clk); #1;
        end
        chk("rst-mid pready before", 32'(pready[1]), 32'd1);
        prstn = 1'b0;
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        chk("rst-mid pready",  32'(pready), 32'h0);
        chk("rst-mid pslverr", 32'(pslverr), 32'h0);
        chk("rst-mid prot",    32'(prot_err), 32'h0);
        chk("rst-mid count1",  32'(xcnt[1]), 32'h0);
        chk("rst-mid prdata0", prdata[0], 32'h0);
        prstn = 1'b1;
        exp_cnt = '{0, 0, 0};
        m_lfsr  = 16'hACE1;
        @(posedge clk); #1;
        do_chk(1, 1'b0, 32'h80, 32'h0, 32'hAAAA5555, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            rnd_xfer(1'b1, 32'(i * 4), 32'(i), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bfm_apb_slave_mem
`default_nettype wire
